// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: common state encoding.
package counter_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StExpired = 2'd2
    } cnt_state_e;

endpackage

// File: rtl/strobe_div.sv
// Clock prescaler: while enabled, emits a one-cycle tick every div+1 clocks.
module strobe_div #(
    parameter int unsigned PRE_DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [PRE_DW-1:0] div,
    output logic              tick
);

    logic [PRE_DW-1:0] pre_q;

    assign tick = en && (pre_q == div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else if (clr) begin
            pre_q <= '0;
        end else if (en) begin
            pre_q <= tick ? '0 : pre_q + PRE_DW'(1);
        end
    end

endmodule

// File: rtl/counter_down_timer.sv
// Loadable down-counting interval timer with prescaler and start/expire handshake.
// Periodic auto-reload is built only when COUNTER_DOWN_AUTORELOAD_EN is defined.
module counter_down_timer
    import counter_pkg::*;
#(
    parameter int unsigned DW     = 16,
    parameter int unsigned PRE_DW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DW-1:0]     load_val_i,
    input  logic              start_i,
    input  logic [PRE_DW-1:0] pre_div_i,
    input  logic              auto_i,
    output logic [DW-1:0]     count_o,
    output logic              busy_o,
    output logic              expired_o,
    output logic              done_o
);

    cnt_state_e        state_q;
    logic [DW-1:0]     count_q;
    logic [DW-1:0]     reload_q;
    logic [PRE_DW-1:0] pre_div_q;
    logic              done_q;
    logic              auto_q;

    logic              start_ok;
    logic [DW-1:0]     start_val;
    logic              tick;
    logic              terminal;

    // A start in RUN is ignored; from EXPIRED it restarts from the reload value.
    assign start_ok  = start_i && (state_q != StRun);
    assign start_val = (state_q == StExpired) ? reload_q : count_q;
    assign terminal  = (count_q <= DW'(1));

    strobe_div #(
        .PRE_DW (PRE_DW)
    ) u_strobe_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_i | load_i | start_ok),
        .en   (state_q == StRun),
        .div  (pre_div_q),
        .tick (tick)
    );

`ifdef COUNTER_DOWN_AUTORELOAD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_q <= 1'b0;
        end else if (!clr_i && !load_i && start_ok) begin
            auto_q <= auto_i;
        end
    end
`else
    logic unused_auto;
    assign auto_q      = 1'b0;
    assign unused_auto = auto_i;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= '0;
            reload_q  <= '0;
            pre_div_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clr_i) begin
                count_q <= '0;
                state_q <= StIdle;
            end else if (load_i) begin
                count_q  <= load_val_i;
                reload_q <= load_val_i;
                state_q  <= StIdle;
            end else if (start_ok) begin
                count_q <= start_val;
                if (start_val != '0) begin
                    pre_div_q <= pre_div_i;
                    state_q   <= StRun;
                end else begin
                    state_q <= StExpired;
                    done_q  <= 1'b1;
                end
            end else if (tick) begin
                if (terminal) begin
                    done_q <= 1'b1;
                    if (auto_q && (reload_q != '0)) begin
                        count_q <= reload_q;
                    end else begin
                        count_q <= '0;
                        state_q <= StExpired;
                    end
                end else begin
                    count_q <= count_q - DW'(1);
                end
            end
        end
    end

    assign count_o   = count_q;
    assign busy_o    = (state_q == StRun);
    assign expired_o = (state_q == StExpired);
    assign done_o    = done_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Self-checking bench for counter_down_timer: directed plan items plus random
// operations, with done_o pulses checked against a queue of predicted edges.
module tb_counter_down_timer;

    localparam int DW     = 16;
    localparam int PRE_DW = 8;
`ifdef COUNTER_DOWN_AUTORELOAD_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_i, load_i, start_i, auto_i;
    logic [DW-1:0]     load_val_i;
    logic [PRE_DW-1:0] pre_div_i;
    logic [DW-1:0]     count_o;
    logic              busy_o, expired_o, done_o;

    counter_down_timer #(
        .DW     (DW),
        .PRE_DW (PRE_DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .start_i    (start_i),
        .pre_div_i  (pre_div_i),
        .auto_i     (auto_i),
        .count_o    (count_o),
        .busy_o     (busy_o),
        .expired_o  (expired_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    // Reference model: mode 0 idle, 1 started run (may have finished), 2 expired.
    int m_mode, m_cnt, m_reload, m_e0, m_n, m_p;
    bit m_auto;
    int done_q[$];

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int st_at(input int e);
        int k;
        if (m_mode != 1) return m_mode;
        k = (e - m_e0) / (m_p + 1);
        if (!m_auto && k >= m_n) return 2;
        return 1;
    endfunction

    function automatic int cnt_at(input int e);
        int k;
        if (m_mode == 0) return m_cnt;
        if (m_mode == 2) return 0;
        k = (e - m_e0) / (m_p + 1);
        if (m_auto) return m_n - (k % m_n);
        return (k >= m_n) ? 0 : m_n - k;
    endfunction

    function automatic void flush_from(input int e);
        int keep[$];
        foreach (done_q[i]) if (done_q[i] < e) keep.push_back(done_q[i]);
        done_q = keep;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_cnt = 0; m_reload = 0; m_auto = 1'b0;
        done_q.delete();
    endfunction

    function automatic void model_edge(input bit c, input bit l, input bit s,
                                       input int val, input int p, input bit a, input int e);
        int st, v;
        if (c) begin
            flush_from(e);
            m_mode = 0; m_cnt = 0;
        end else if (l) begin
            flush_from(e);
            m_mode = 0; m_cnt = val; m_reload = val;
        end else if (s) begin
            st = st_at(e - 1);
            if (st != 1) begin
                v = (st == 2) ? m_reload : m_cnt;
                if (v == 0) begin
                    m_mode = 2;
                    done_q.push_back(e);
                end else begin
                    m_mode = 1; m_e0 = e; m_n = v; m_p = p;
                    m_auto = AUTO_EN && a && (m_reload != 0);
                    done_q.push_back(e + v * (p + 1));
                end
            end
        end
    endfunction

    task automatic drive(input bit c, input bit l, input bit s,
                         input int val, input int p, input bit a);
        clr_i = c; load_i = l; start_i = s;
        load_val_i = DW'(val); pre_div_i = PRE_DW'(p); auto_i = a;
        @(posedge clk); #2;
        model_edge(c, l, s, val, p, a, cyc);
        clr_i = 1'b0; load_i = 1'b0; start_i = 1'b0;
    endtask

    // Idle cycles scramble pre_div_i/auto_i: they must not matter outside a start.
    task automatic idle(input int n);
        repeat (n) begin
            pre_div_i = PRE_DW'($urandom);
            auto_i    = 1'($urandom);
            @(posedge clk); #2;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                chk("done_edge_missed", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", cyc, -1);
                end else begin
                    chk("done_edge", cyc, done_q[0]);
                    void'(done_q.pop_front());
                    if (m_mode == 1 && m_auto) done_q.push_back(cyc + m_n * (m_p + 1));
                end
            end else if (done_q.size() > 0 && done_q[0] == cyc) begin
                chk("done_pulse", int'(done_o), 1);
                void'(done_q.pop_front());
            end
            chk("count", int'(count_o), cnt_at(cyc));
            chk("busy", int'(busy_o), int'(st_at(cyc) == 1));
            chk("expired", int'(expired_o), int'(st_at(cyc) == 2));
        end
    end

    initial begin
        int e0, got, last, op;
        rst = 1'b1; clr_i = 1'b0; load_i = 1'b0; start_i = 1'b0;
        load_val_i = '0; pre_div_i = '0; auto_i = 1'b0;
        model_reset();
        #3;
        chk("reset_count", int'(count_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_expired", int'(expired_o), 0);
        chk("reset_done", int'(done_o), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        mon_en = 1'b1;

        // load 5, P=0: count 5..0, done with count 0 on the 5th cycle
        drive(0, 1, 0, 5, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        for (int i = 0; i <= 5; i++) begin
            chk("seq_count", int'(count_o), 5 - i);
            chk("seq_done", int'(done_o), int'(i == 5));
            if (i < 5) idle(1);
        end
        chk("seq_expired", int'(expired_o), 1);

        // load 3, P=2: done 9 clocks after start despite pre_div_i changing
        drive(0, 1, 0, 3, 0, 0);
        drive(0, 0, 1, 0, 2, 0);
        e0 = cyc; got = -1;
        for (int i = 0; i < 30 && got < 0; i++) begin
            idle(1);
            if (done_o) got = cyc - e0;
        end
        chk("p2_latency", got, 9);

        // load 4, P=1, auto: 8-clock period (single-shot when compiled out)
        drive(0, 1, 0, 4, 0, 0);
        drive(0, 0, 1, 0, 1, 1);
        last = cyc; got = 0;
        for (int i = 0; i < 45 && got < 5; i++) begin
            idle(1);
            if (done_o) begin
                chk("auto_period", cyc - last, 8);
                last = cyc;
                got++;
            end
            if (AUTO_EN) chk("auto_busy", int'(busy_o), 1);
        end
        chk("auto_pulses", got, AUTO_EN ? 5 : 1);
        drive(1, 0, 0, 0, 0, 0);

        // start in RUN ignored; clr on the terminal tick edge suppresses done
        drive(0, 1, 0, 3, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 1, 0, 3, 1);
        chk("ign_start_count", int'(count_o), 2);
        chk("ign_start_busy", int'(busy_o), 1);
        idle(1);
        drive(1, 0, 0, 0, 0, 0);
        chk("clr_tick_done", int'(done_o), 0);
        chk("clr_tick_count", int'(count_o), 0);
        chk("clr_tick_busy", int'(busy_o), 0);
        chk("clr_tick_expired", int'(expired_o), 0);
        idle(3);

        // zero-count start expires at once; start from EXPIRED reloads 5
        drive(0, 1, 0, 5, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        chk("zero_start_done", int'(done_o), 1);
        chk("zero_start_expired", int'(expired_o), 1);
        drive(0, 0, 1, 0, 0, 0);
        chk("restart_count", int'(count_o), 5);
        chk("restart_busy", int'(busy_o), 1);
        idle(5);
        chk("restart_done", int'(done_o), 1);
        chk("restart_final", int'(count_o), 0);

        // asynchronous reset in the middle of a run
        drive(0, 1, 0, 6, 0, 0);
        drive(0, 0, 1, 0, 3, 0);
        idle(5);
        rst = 1'b1;
        #1;
        chk("rst_run_count", int'(count_o), 0);
        chk("rst_run_busy", int'(busy_o), 0);
        chk("rst_run_expired", int'(expired_o), 0);
        chk("rst_run_done", int'(done_o), 0);
        model_reset();
        @(posedge clk); #2;
        rst = 1'b0;

        // random operation mix, all checked by the monitor
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: drive(0, 1, 0, $urandom_range(0, 6), 0, 0);
                3, 4, 5: drive(0, 0, 1, 0, $urandom_range(0, 3), 1'($urandom));
                6:       drive(1, 0, 0, 0, 0, 0);
                7:       drive(1'($urandom), 1'($urandom), 1'($urandom),
                               $urandom_range(0, 6), $urandom_range(0, 3), 1'($urandom));
                default: idle($urandom_range(0, 30));
            endcase
        end

        drive(1, 0, 0, 0, 0, 0);
        idle(2);
        chk("sb_drain", done_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
